sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock first-in/first-out buffer with registered read data and full/empty/count status.
//  It decouples a producer and a consumer that share one clock domain.
//  Write accept: wr_en && !full. Read accept: rd_en && !empty (see simultaneous rules).
//  Overflow and underflow are flagged, never corrupting.
// PARAMETERS
//  DATA_WIDTH  8  width of data_in/data_out
//  DEPTH       8  number of entries; must be a power of 2, >= 2
//  ADDR_WIDTH  3  log2(DEPTH); pointers carry ADDR_WIDTH+1 bits (wrap bit)
// PORTS
//  clk        in   1             rising-edge clock, single domain
//  rst        in   1             synchronous reset, active-high
//  wr_en      in   1             write request; data_in is sampled on the same edge
//  rd_en      in   1             read request
//  data_in    in   DATA_WIDTH    write data
//  data_out   out  DATA_WIDTH    registered read data
//  full       out  1             count == DEPTH
//  empty      out  1             count == 0
//  count      out  ADDR_WIDTH+1  occupancy, range 0..DEPTH
//  overflow   out  1             1-cycle pulse: wr_en while full and no read accepted
//  underflow  out  1             1-cycle pulse: rd_en while empty
// BEHAVIOUR
//  - Reset: sampled only at posedge clk while rst=1, and overrides all requests.
//    State after reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, data_out=0,
//    overflow=0, underflow=0. Memory contents are don't-care.
//    A reset mid-operation discards all stored entries.
//  - Write: on an accepted write, mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in and wr_ptr increments.
//  - Read: on an accepted read, data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]] and rd_ptr increments.
//    data_out is valid after that edge (1-cycle latency).
//    data_out holds its last value when no read is accepted.
//  - Wrap: pointers increment modulo 2*DEPTH; the index uses the low ADDR_WIDTH bits.
//  - Status: full/empty are derived from registered state and are valid in the cycle after
//    the causing edge.
//  - Simultaneous wr_en && rd_en:
//      not empty and not full -> both accepted, count unchanged.
//      full  -> both accepted (read frees the slot), count stays DEPTH, no overflow.
//      empty -> write only; no read and no bypass; data_out unchanged; underflow pulses.
//  - Rejected write leaves memory and pointers untouched. Rejected read leaves data_out unchanged.
//  - count: +1 on write-only accept, -1 on read-only accept, else hold; never exceeds DEPTH.
//  - overflow/underflow are registered, high exactly one cycle per offending request cycle.
// TESTING
//  1. Reset: assert rst 1 cycle -> empty=1, full=0, count=0, data_out=0.
//  2. Fill: write 0..7 on consecutive cycles -> count 1..8; full=1 after the 8th edge;
//     empty=0 after the 1st edge.
//  3. Overflow: while full, wr_en=1 with data 8'hAA for 1 cycle -> overflow pulses once;
//     count stays 8; 8'hAA is never read.
//  4. Drain: rd_en for 8 cycles -> data_out = 0,1,...,7, each one edge after its request;
//     empty=1 after the 8th read; a further rd_en -> underflow pulses, data_out stays 7.
//  5. Wrap and simultaneous: write 0..7 again, then wr_en=rd_en=1 for 4 cycles with data 8..11
//     -> reads give 0..3, count stays 8, full stays 1; drain -> 4..11 in order.
//  6. Mid-reset: after 3 writes, assert rst -> count=0, empty=1;
//     next write 8'h5C then read -> data_out=8'h5C.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, full/empty/count status and
// one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      count_nxt;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    // A write into a full FIFO is still accepted when a read frees the slot on the same edge.
    always_comb begin
        rd_acc_c  = rd_en && !empty;
        wr_acc_c  = wr_en && (!full || rd_acc_c);
        count_nxt = count;
        if (wr_acc_c && !rd_acc_c) begin
            count_nxt = count + PTR_W'(1);
        end else if (rd_acc_c && !wr_acc_c) begin
            count_nxt = count - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            data_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc_c) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            count     <= count_nxt;
            full      <= (count_nxt == PTR_W'(DEPTH));
            empty     <= (count_nxt == '0);
            overflow  <= wr_en && full && !rd_acc_c;
            underflow <= rd_en && empty;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts every
// post-edge output set, and a negedge monitor compares them against the DUT.
module tb_sync_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        logic [DW-1:0] dout;
        int            cnt;
        bit            full;
        bit            empty;
        bit            ovf;
        bit            unf;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_dout = '0;
    int            total  = 0;
    int            bad    = 0;
    int            cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cycle=%0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: every edge produces one expectation, checked half a period later.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_out",  32'(data_out),  32'(e.dout));
            chk("count",     32'(count),     32'(e.cnt));
            chk("full",      32'(full),      32'(e.full));
            chk("empty",     32'(empty),     32'(e.empty));
            chk("overflow",  32'(overflow),  32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
            cyc++;
        end
    end

    // Drive one cycle of requests and predict the outcome from FIFO semantics.
    task automatic cycle(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        bit   rd_ok;
        bit   wr_ok;
        rst     = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        e.ovf   = 1'b0;
        e.unf   = 1'b0;
        if (r) begin
            model_q.delete();
            m_dout = '0;
        end else begin
            rd_ok = rd && (model_q.size() > 0);
            wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
            e.ovf = w && !wr_ok;
            e.unf = rd && (model_q.size() == 0);
            if (rd_ok) m_dout = model_q.pop_front();
            if (wr_ok) model_q.push_back(d);
        end
        e.dout  = m_dout;
        e.cnt   = model_q.size();
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    initial begin
        int wr_pct;
        int rd_pct;

        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        cycle(1'b0, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, DW'(8 + i));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b1, 1'b1, 8'h33);
        cycle(1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, DW'(8'h20 + i));
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, 8'h5C);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Random segments with skewed rates push the FIFO toward full, empty and steady flow.
        for (int s = 0; s < 40; s++) begin
            wr_pct = (s % 3 == 0) ? 85 : (s % 3 == 1) ? 50 : 15;
            rd_pct = (s % 3 == 0) ? 20 : (s % 3 == 1) ? 50 : 85;
            for (int k = 0; k < 50; k++) begin
                cycle($urandom_range(0, 299) == 0,
                      $urandom_range(0, 99) < wr_pct,
                      $urandom_range(0, 99) < rd_pct,
                      DW'($urandom));
            end
        end
        cycle(1'b0, 1'b0, 1'b0, '0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
